hbm_clk_rst_seq: RTL and testbench



---
 rtl/hbm_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/hbm_clk_rst_seq.sv | 173 +++++++++++++++++
 tb/tb_hbm_clk_rst_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbm_seq_pkg.sv
// Shared types and constants for the HBM clock/reset sequencer.
package hbm_seq_pkg;

  // Sequencer states; the encodings are exported on seq_state for debug
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOCK_WAIT = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } seq_state_e;

  // Lock-loss events are counted up to this value and then held
  localparam logic [7:0] RELOCK_MAX = 8'hFF;

  // Saturating increment for the lock-loss event counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == RELOCK_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Two back-to-back flops give the metastable first stage a full cycle to settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/hbm_clk_rst_seq.sv
// HBM clock-lock qualifier and staggered per-channel reset sequencer.
// Qualifies a raw PLL/MMCM lock, releases channel resets one slot at a time,
// and forces a full re-sequence when a filtered loss of lock is seen.
module hbm_clk_rst_seq
  import hbm_seq_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned LOCK_CYCLES    = 10,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned LOSS_FILTER    = 3,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked_raw,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic              hbm_clk_locked,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              seq_done,
  output logic [7:0]        relock_count,
  output logic [2:0]        seq_state
);

  // idx counts release slots already handed out, so it must be able to hold NUM_CH
  localparam int unsigned IDX_W = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES);
  localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
  localparam logic [IDX_W-1:0] IDX_ALL      = IDX_W'(NUM_CH);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

  logic lk_s;

  seq_state_e        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [CNT_W-1:0]  loss_q,    loss_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic              locked_q,  locked_d;
  logic [NUM_CH-1:0] ch_rst_q,  ch_rst_d;
  logic              done_q,    done_d;
  logic [7:0]        relock_q,  relock_d;
  logic              loss_hit;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked_raw),
    .q   (lk_s)
  );

  // Next-state and next-output logic for the whole sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_d   = loss_q;
    idx_d    = idx_q;
    locked_d = locked_q;
    ch_rst_d = ch_rst_q;
    done_d   = done_q;
    relock_d = relock_q;

    loss_hit = !lk_s && (loss_q == LOSS_LAST);

    unique case (state_q)
      ST_IDLE: begin
        ch_rst_d = '1;
        locked_d = 1'b0;
        done_d   = 1'b0;
        cnt_d    = '0;
        if (lk_s) begin
          state_d = ST_LOCK_WAIT;
          cnt_d   = CNT_ONE;
        end
      end

      ST_LOCK_WAIT: begin
        if (!lk_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          // Entering RELEASE is itself release slot 0, so channel 0 is
          // handled on this edge and the stagger count restarts at 1
          state_d  = ST_RELEASE;
          locked_d = 1'b1;
          cnt_d    = CNT_ONE;
          loss_d   = '0;
          idx_d    = IDX_ONE;
          if (ch_enable[0]) begin
            ch_rst_d[0] = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RELEASE, ST_RUN: begin
        if (loss_hit) begin
          // A filtered loss wins over any release due on the same edge
          state_d  = ST_LOST;
          ch_rst_d = '1;
          locked_d = 1'b0;
          done_d   = 1'b0;
          relock_d = sat_inc8(relock_q);
          loss_d   = '0;
          cnt_d    = '0;
          idx_d    = '0;
        end else begin
          loss_d = lk_s ? '0 : (loss_q + CNT_ONE);
          if (state_q == ST_RELEASE) begin
            if (idx_q == IDX_ALL) begin
              // Every slot has been handed out; the extra cycle here keeps
              // RELEASE at least one cycle long even for a single channel
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else if (cnt_q == STAGGER_LAST) begin
              cnt_d = CNT_ONE;
              idx_d = idx_q + IDX_ONE;
              for (int i = 0; i < NUM_CH; i++) begin
                if ((idx_q == IDX_W'(i)) && ch_enable[i]) begin
                  ch_rst_d[i] = 1'b0;
                end
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            ch_rst_d = ~ch_enable;
          end
        end
      end

      ST_LOST: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single register bank for the FSM state, counters and every output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      loss_q   <= '0;
      idx_q    <= '0;
      locked_q <= 1'b0;
      ch_rst_q <= '1;
      done_q   <= 1'b0;
      relock_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loss_q   <= loss_d;
      idx_q    <= idx_d;
      locked_q <= locked_d;
      ch_rst_q <= ch_rst_d;
      done_q   <= done_d;
      relock_q <= relock_d;
    end
  end

  assign hbm_clk_locked = locked_q;
  assign ch_rst         = ch_rst_q;
  assign seq_done       = done_q;
  assign relock_count   = relock_q;
  assign seq_state      = state_q;

endmodule

// File: tb/tb_hbm_clk_rst_seq.sv
// Testbench for hbm_clk_rst_seq: directed timing tables, hand-written
// multi-cycle corner cases, and randomized lock/enable traffic checked
// against a time-based behavioural model.
module tb_hbm_clk_rst_seq;

  localparam int NUM_CH         = 4;
  localparam int LOCK_CYCLES    = 10;
  localparam int STAGGER_CYCLES = 4;
  localparam int LOSS_FILTER    = 3;

  localparam int P_IDLE = 0;
  localparam int P_QUAL = 1;
  localparam int P_REL  = 2;
  localparam int P_RUN  = 3;
  localparam int P_LOST = 4;

  logic              clk;
  logic              rst;
  logic              pll_locked_raw;
  logic [NUM_CH-1:0] ch_enable;
  logic              hbm_clk_locked;
  logic [NUM_CH-1:0] ch_rst;
  logic              seq_done;
  logic [7:0]        relock_count;
  logic [2:0]        seq_state;

  int checks;
  int failures;

  // Model state: sync pipeline, phase, and elapsed-time bookkeeping
  logic              m_s1, m_s2;
  int                m_state;
  int                m_run;
  int                m_t;
  int                m_low;
  logic              m_locked;
  logic [NUM_CH-1:0] m_ch_rst;
  logic              m_done;
  int                m_relock;

  typedef struct {
    logic        raw;
    logic [3:0]  en;
    int          cycles;
    logic        locked;
    logic [3:0]  rst_bits;
    logic        done;
    logic [2:0]  state;
  } vec_t;

  vec_t vecs_a[9];
  vec_t vecs_b[5];

  hbm_clk_rst_seq #(
    .NUM_CH         (NUM_CH),
    .LOCK_CYCLES    (LOCK_CYCLES),
    .STAGGER_CYCLES (STAGGER_CYCLES),
    .LOSS_FILTER    (LOSS_FILTER),
    .CNT_W          (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked_raw (pll_locked_raw),
    .ch_enable      (ch_enable),
    .hbm_clk_locked (hbm_clk_locked),
    .ch_rst         (ch_rst),
    .seq_done       (seq_done),
    .relock_count   (relock_count),
    .seq_state      (seq_state)
  );

  // Free-running reference clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_s1     = 1'b0;
    m_s2     = 1'b0;
    m_state  = P_IDLE;
    m_run    = 0;
    m_t      = 0;
    m_low    = 0;
    m_locked = 1'b0;
    m_ch_rst = '1;
    m_done   = 1'b0;
    m_relock = 0;
  endtask

  // One clock edge of the behavioural model; releases are derived from
  // elapsed time since lock (slot i is due at i*STAGGER_CYCLES)
  task automatic modelStep();
    logic lk;
    lk   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked_raw;
    case (m_state)
      P_IDLE: begin
        if (lk) begin
          m_state = P_QUAL;
          m_run   = 1;
        end
      end
      P_QUAL: begin
        if (!lk) begin
          m_state = P_IDLE;
        end else if (m_run == LOCK_CYCLES) begin
          m_state  = P_REL;
          m_locked = 1'b1;
          m_t      = 0;
          m_low    = 0;
          if (ch_enable[0]) m_ch_rst[0] = 1'b0;
        end else begin
          m_run++;
        end
      end
      P_REL, P_RUN: begin
        m_low = lk ? 0 : m_low + 1;
        if (m_low == LOSS_FILTER) begin
          m_state  = P_LOST;
          m_ch_rst = '1;
          m_locked = 1'b0;
          m_done   = 1'b0;
          if (m_relock < 255) m_relock++;
        end else if (m_state == P_REL) begin
          m_t++;
          if (m_t == (NUM_CH - 1) * STAGGER_CYCLES + 1) begin
            m_state = P_RUN;
            m_done  = 1'b1;
          end else begin
            for (int i = 0; i < NUM_CH; i++) begin
              if ((i * STAGGER_CYCLES == m_t) && ch_enable[i]) m_ch_rst[i] = 1'b0;
            end
          end
        end else begin
          m_ch_rst = ~ch_enable;
        end
      end
      default: begin
        m_state = P_IDLE;
      end
    endcase
  endtask

  task automatic checkOutput(input string ctx);
    checkVal({ctx, ".locked"},       32'(hbm_clk_locked), 32'(m_locked));
    checkVal({ctx, ".ch_rst"},       32'(ch_rst),         32'(m_ch_rst));
    checkVal({ctx, ".seq_done"},     32'(seq_done),       32'(m_done));
    checkVal({ctx, ".relock_count"}, 32'(relock_count),   32'(m_relock));
    checkVal({ctx, ".seq_state"},    32'(seq_state),      32'(m_state));
  endtask

  // Hold inputs for n edges, stepping the model and comparing after each edge
  task automatic applyStimulus(input logic raw, input logic [NUM_CH-1:0] en, input int n, input string ctx);
    pll_locked_raw = raw;
    ch_enable      = en;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      modelStep();
      #1;
      checkOutput(ctx);
    end
  endtask

  // Called one time unit after an edge; releases reset one unit after a later edge
  task automatic doReset();
    rst            = 1'b1;
    pll_locked_raw = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset");
  endtask

  task automatic runTable(input vec_t v, input string ctx);
    applyStimulus(v.raw, v.en, v.cycles, ctx);
    checkVal({ctx, ".tbl_locked"}, 32'(hbm_clk_locked), 32'(v.locked));
    checkVal({ctx, ".tbl_ch_rst"}, 32'(ch_rst),         32'(v.rst_bits));
    checkVal({ctx, ".tbl_done"},   32'(seq_done),       32'(v.done));
    checkVal({ctx, ".tbl_state"},  32'(seq_state),      32'(v.state));
  endtask

  initial begin
    logic              lvl;
    int                len;
    logic [NUM_CH-1:0] ren;

    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    pll_locked_raw = 1'b0;
    ch_enable      = 4'hF;
    modelReset();

    // Full sequence with all channels enabled, then enable toggling in RUN
    vecs_a[0] = '{1'b1, 4'hF, 12, 1'b0, 4'hF, 1'b0, 3'd1};
    vecs_a[1] = '{1'b1, 4'hF,  1, 1'b1, 4'hE, 1'b0, 3'd2};
    vecs_a[2] = '{1'b1, 4'hF,  3, 1'b1, 4'hE, 1'b0, 3'd2};
    vecs_a[3] = '{1'b1, 4'hF,  1, 1'b1, 4'hC, 1'b0, 3'd2};
    vecs_a[4] = '{1'b1, 4'hF,  4, 1'b1, 4'h8, 1'b0, 3'd2};
    vecs_a[5] = '{1'b1, 4'hF,  4, 1'b1, 4'h0, 1'b0, 3'd2};
    vecs_a[6] = '{1'b1, 4'hF,  1, 1'b1, 4'h0, 1'b1, 3'd3};
    vecs_a[7] = '{1'b1, 4'hE,  1, 1'b1, 4'h1, 1'b1, 3'd3};
    vecs_a[8] = '{1'b1, 4'hF,  1, 1'b1, 4'h0, 1'b1, 3'd3};

    // Only channels 1 and 3 enabled: they release at slots 1 and 3
    vecs_b[0] = '{1'b1, 4'hA, 13, 1'b1, 4'hF, 1'b0, 3'd2};
    vecs_b[1] = '{1'b1, 4'hA,  4, 1'b1, 4'hD, 1'b0, 3'd2};
    vecs_b[2] = '{1'b1, 4'hA,  4, 1'b1, 4'hD, 1'b0, 3'd2};
    vecs_b[3] = '{1'b1, 4'hA,  4, 1'b1, 4'h5, 1'b0, 3'd2};
    vecs_b[4] = '{1'b1, 4'hA,  1, 1'b1, 4'h5, 1'b1, 3'd3};

    doReset();
    for (int i = 0; i < 9; i++) runTable(vecs_a[i], $sformatf("tblA%0d", i));

    doReset();
    for (int i = 0; i < 5; i++) runTable(vecs_b[i], $sformatf("tblB%0d", i));

    // One-cycle raw drop while qualifying restarts the lock count
    doReset();
    applyStimulus(1'b1, 4'hF, 8,  "glitch");
    applyStimulus(1'b0, 4'hF, 1,  "glitch");
    applyStimulus(1'b1, 4'hF, 12, "glitch");
    checkVal("glitch.locked_early", 32'(hbm_clk_locked), 32'd0);
    applyStimulus(1'b1, 4'hF, 1,  "glitch");
    checkVal("glitch.locked",       32'(hbm_clk_locked), 32'd1);
    checkVal("glitch.relock",       32'(relock_count),   32'd0);

    // Short loss in RUN is filtered; a three-cycle loss forces LOST and re-sequence
    applyStimulus(1'b1, 4'hF, 15, "loss");
    checkVal("loss.run_state", 32'(seq_state), 32'd3);
    applyStimulus(1'b0, 4'hF, 2, "loss");
    applyStimulus(1'b1, 4'hF, 5, "loss");
    checkVal("loss.filtered_state",  32'(seq_state),    32'd3);
    checkVal("loss.filtered_relock", 32'(relock_count), 32'd0);
    applyStimulus(1'b0, 4'hF, 3, "loss");
    applyStimulus(1'b1, 4'hF, 1, "loss");
    checkVal("loss.pre_state", 32'(seq_state), 32'd3);
    applyStimulus(1'b1, 4'hF, 1, "loss");
    checkVal("loss.lost_state",  32'(seq_state),      32'd4);
    checkVal("loss.lost_ch_rst", 32'(ch_rst),         32'hF);
    checkVal("loss.lost_locked", 32'(hbm_clk_locked), 32'd0);
    checkVal("loss.lost_relock", 32'(relock_count),   32'd1);
    applyStimulus(1'b1, 4'hF, 30, "loss");
    checkVal("loss.reseq_done", 32'(seq_done), 32'd1);

    // Repeated loss events saturate the relock counter
    for (int e = 0; e < 260; e++) begin
      applyStimulus(1'b1, 4'hF, 16, "sat");
      applyStimulus(1'b0, 4'hF, 5,  "sat");
    end
    checkVal("sat.relock", 32'(relock_count), 32'd255);

    // Asynchronous reset in the middle of RELEASE
    applyStimulus(1'b1, 4'hF, 16, "midrst");
    checkVal("midrst.state_before", 32'(seq_state), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    checkVal("midrst.locked", 32'(hbm_clk_locked), 32'd0);
    checkVal("midrst.ch_rst", 32'(ch_rst),         32'hF);
    checkVal("midrst.done",   32'(seq_done),       32'd0);
    checkVal("midrst.relock", 32'(relock_count),   32'd0);
    checkVal("midrst.state",  32'(seq_state),      32'd0);
    @(posedge clk);
    #1;
    doReset();

    // Randomized lock bursts and occasional enable changes
    ren = 4'hF;
    for (int k = 0; k < 150; k++) begin
      lvl = 1'($urandom_range(0, 1));
      len = lvl ? $urandom_range(1, 40) : $urandom_range(1, 6);
      if ($urandom_range(0, 3) == 0) ren = 4'($urandom);
      applyStimulus(lvl, ren, len, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
